// File: rtl/vip_pkg.sv
// Shared encodings for the pattern generator: modes, FSM states, colour-bar table.
package vip_pkg;

   localparam int unsigned FCW = 16;

   typedef enum logic [1:0] {
      MODE_RAMP  = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_FLAT  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // {R,G,B} on/off bits for bars 0..7: white, yellow, cyan, green, magenta, red, blue, black
   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      logic [2:0] rgb;
      case (idx)
         3'd0:    rgb = 3'b111;
         3'd1:    rgb = 3'b110;
         3'd2:    rgb = 3'b011;
         3'd3:    rgb = 3'b010;
         3'd4:    rgb = 3'b101;
         3'd5:    rgb = 3'b100;
         3'd6:    rgb = 3'b001;
         default: rgb = 3'b000;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/vip_pattern_lut.sv
// Combinational pixel colour for the current position, frame count and pattern mode.
module vip_pattern_lut
   import vip_pkg::*;
#(
   parameter int unsigned DWIDTH = 24,
   parameter int unsigned XW     = 12,
   parameter int unsigned YW     = 12,
   parameter int unsigned SQ     = 3
) (
   input  mode_e             mode,
   input  logic [XW-1:0]     x,
   input  logic [YW-1:0]     y,
   input  logic [2:0]        bar_idx,
   input  logic [FCW-1:0]    frame_cnt,
   output logic [DWIDTH-1:0] data
);

   localparam int unsigned CW = DWIDTH / 3;

   logic [CW-1:0] r, g, b;
   logic [2:0]    rgb;
   logic          chk;

   // Bits beyond the channel width only matter to other modes
   logic unused_bits;
   assign unused_bits = ^{x, y, frame_cnt};

   assign rgb = bar_rgb(bar_idx);
   assign chk = x[SQ] ^ y[SQ];

   always_comb begin
      r = '0;
      g = '0;
      b = '0;
      case (mode)
         MODE_RAMP: begin
            r = CW'(x);
            g = CW'(y);
            b = CW'(x) + CW'(y);
         end
         MODE_BARS: begin
            r = {CW{rgb[2]}};
            g = {CW{rgb[1]}};
            b = {CW{rgb[0]}};
         end
         MODE_CHECK: begin
            r = {CW{chk}};
            g = {CW{chk}};
            b = {CW{chk}};
         end
         default: begin
            r = CW'(frame_cnt);
            g = CW'(frame_cnt);
            b = CW'(frame_cnt);
         end
      endcase
   end

   assign data = DWIDTH'({r, g, b});

endmodule

// File: rtl/vip_pattern_gen.sv
// Test-pattern frame source writing RGB pixels into a FIFO with back-pressure.
module vip_pattern_gen
   import vip_pkg::*;
#(
   parameter int unsigned DWIDTH = 24,
   parameter int unsigned IMG_W  = 640,
   parameter int unsigned IMG_H  = 480,
   parameter int unsigned XW     = 12,
   parameter int unsigned YW     = 12,
   parameter int unsigned FRAMES = 0,
   parameter int unsigned SQ     = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic              fifo_full,
   output logic [DWIDTH-1:0] fifo_data,
   output logic              fifo_wrreq,
   output logic              sof,
   output logic              eol,
   output logic              frame_done,
   output logic              busy
);

   localparam int unsigned BAR_W = IMG_W / 8;

   state_e         state_q, state_d;
   mode_e          mode_q, mode_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
   logic [2:0]     bar_idx_q, bar_idx_d;
   logic [XW-1:0]  bar_cnt_q, bar_cnt_d;
   logic           frame_done_q, frame_done_d;

   logic wr, last_x, last_y;

   assign wr     = (state_q == RUN) && !fifo_full;
   assign last_x = (x_q == XW'(IMG_W - 1));
   assign last_y = (y_q == YW'(IMG_H - 1));

   // State and counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         mode_q       <= MODE_RAMP;
         x_q          <= '0;
         y_q          <= '0;
         frame_cnt_q  <= '0;
         bar_idx_q    <= '0;
         bar_cnt_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         x_q          <= x_d;
         y_q          <= y_d;
         frame_cnt_q  <= frame_cnt_d;
         bar_idx_q    <= bar_idx_d;
         bar_cnt_q    <= bar_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next state; counters move only on write cycles
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      x_d          = x_q;
      y_d          = y_q;
      frame_cnt_d  = frame_cnt_q;
      bar_idx_d    = bar_idx_q;
      bar_cnt_d    = bar_cnt_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d   = RUN;
               mode_d    = mode_e'(mode);
               x_d       = '0;
               y_d       = '0;
               bar_idx_d = '0;
               bar_cnt_d = '0;
            end
         end
         RUN: begin
            if (wr) begin
               if (last_x) begin
                  x_d       = '0;
                  bar_idx_d = '0;
                  bar_cnt_d = '0;
                  if (last_y) begin
                     y_d          = '0;
                     frame_cnt_d  = frame_cnt_q + FCW'(1);
                     frame_done_d = 1'b1;
                     if ((FRAMES != 0) && (frame_cnt_d == FCW'(FRAMES))) begin
                        state_d = DONE;
                     end else if (!enable) begin
                        state_d = IDLE;
                     end else begin
                        mode_d = mode_e'(mode);
                     end
                  end else begin
                     y_d = y_q + YW'(1);
                  end
               end else begin
                  x_d = x_q + XW'(1);
                  if (bar_cnt_q == XW'(BAR_W - 1)) begin
                     bar_cnt_d = '0;
                     bar_idx_d = bar_idx_q + 3'(1);
                  end else begin
                     bar_cnt_d = bar_cnt_q + XW'(1);
                  end
               end
            end
         end
         DONE: begin
            if (!enable) begin
               state_d     = IDLE;
               frame_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   vip_pattern_lut #(
      .DWIDTH (DWIDTH),
      .XW     (XW),
      .YW     (YW),
      .SQ     (SQ)
   ) u_lut (
      .mode      (mode_q),
      .x         (x_q),
      .y         (y_q),
      .bar_idx   (bar_idx_q),
      .frame_cnt (frame_cnt_q),
      .data      (fifo_data)
   );

   assign fifo_wrreq = wr;
   assign busy       = (state_q == RUN);
   assign sof        = wr && (x_q == '0) && (y_q == '0);
   assign eol        = wr && last_x;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vip_pattern_gen.sv
// Scoreboard bench: one bounded-frame and one continuous generator on a 16x4 image.
module tb_vip_pattern_gen;

   localparam int W = 16;
   localparam int H = 4;

   typedef struct packed {
      logic [23:0] data;
      logic        sof;
      logic        eol;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b0, en_a = 1'b0, full_a = 1'b0;
   logic [1:0]  mode_a = 2'd0;
   logic [23:0] data_a;
   logic        wr_a, sof_a, eol_a, fd_a, busy_a;

   logic        rst_b = 1'b0, en_b = 1'b0, full_b = 1'b0;
   logic [1:0]  mode_b = 2'd0;
   logic [23:0] data_b;
   logic        wr_b, sof_b, eol_b, fd_b, busy_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int checks = 0;
   int errors = 0;

   int wc_a = 0, eol_cnt_a = 0, full_run_a = 0, stall_a = 0;
   int wc_b = 0;
   logic [23:0] cap_a = '0, cap_b = '0;

   vip_pattern_gen #(.DWIDTH(24), .IMG_W(W), .IMG_H(H), .XW(12), .YW(12), .FRAMES(1), .SQ(3)) dut_a (
      .clock(clk), .reset(rst_a), .enable(en_a), .mode(mode_a), .fifo_full(full_a),
      .fifo_data(data_a), .fifo_wrreq(wr_a), .sof(sof_a), .eol(eol_a),
      .frame_done(fd_a), .busy(busy_a));

   vip_pattern_gen #(.DWIDTH(24), .IMG_W(W), .IMG_H(H), .XW(12), .YW(12), .FRAMES(0), .SQ(3)) dut_b (
      .clock(clk), .reset(rst_b), .enable(en_b), .mode(mode_b), .fifo_full(full_b),
      .fifo_data(data_b), .fifo_wrreq(wr_b), .sof(sof_b), .eol(eol_b),
      .frame_done(fd_b), .busy(busy_b));

   function automatic logic [23:0] model(input int m, input int x, input int y, input int fc);
      logic [23:0] v;
      case (m)
         0: v = {8'(x), 8'(y), 8'(x + y)};
         1: begin
            case (x / (W / 8))
               0: v = 24'hFFFFFF;
               1: v = 24'hFFFF00;
               2: v = 24'h00FFFF;
               3: v = 24'h00FF00;
               4: v = 24'hFF00FF;
               5: v = 24'hFF0000;
               6: v = 24'h0000FF;
               default: v = 24'h000000;
            endcase
         end
         2: v = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
         default: v = {3{8'(fc)}};
      endcase
      return v;
   endfunction

   task automatic push_frame(input bit sel, input int m, input int fc);
      exp_t e;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            e.data = model(m, x, y, fc);
            e.sof  = (x == 0) && (y == 0);
            e.eol  = (x == W - 1);
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Wait until the chosen scoreboard holds at most 'level' entries; optional 1-in-3 full stalls
   task automatic wait_level(input bit sel, input int level, input int budget, input bit stall);
      int n = 0;
      while (((sel ? q_b.size() : q_a.size()) > level) && n < budget) begin
         @(posedge clk); #2;
         if (stall) begin
            if (sel) full_b = (n % 3 == 2);
            else     full_a = (n % 3 == 2);
         end
         n++;
      end
      checks++;
      assert ((sel ? q_b.size() : q_a.size()) <= level) else begin
         errors++;
         $error("FAIL wait_timeout sel=%0d observed=%0d expected<=%0d", sel, sel ? q_b.size() : q_a.size(), level);
      end
      if (sel) full_b = 1'b0;
      else     full_a = 1'b0;
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!rst_a) wc_a = 0;
      if (busy_a && full_a)  full_run_a++;
      if (busy_a && !wr_a)   stall_a++;
      if (wr_a) begin
         checks++;
         assert (!full_a) else begin
            errors++;
            $error("FAIL wr_while_full_a observed=1 expected=0");
         end
         checks++;
         assert (q_a.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write_a observed=%h expected=none", data_a);
         end
         if (q_a.size() != 0) begin
            e = q_a.pop_front();
            checks++;
            assert ({data_a, sof_a, eol_a} === e) else begin
               errors++;
               $error("FAIL pix_a wc=%0d observed=%h expected=%h", wc_a, {data_a, sof_a, eol_a}, e);
            end
         end
         if (eol_a) eol_cnt_a++;
         if (wc_a == 37) cap_a = data_a;
         wc_a++;
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!rst_b) wc_b = 0;
      if (wr_b) begin
         checks++;
         assert (q_b.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write_b observed=%h expected=none", data_b);
         end
         if (q_b.size() != 0) begin
            e = q_b.pop_front();
            checks++;
            assert ({data_b, sof_b, eol_b} === e) else begin
               errors++;
               $error("FAIL pix_b wc=%0d observed=%h expected=%h", wc_b, {data_b, sof_b, eol_b}, e);
            end
         end
         if (wc_b == 200) cap_b = data_b;
         wc_b++;
      end
   end

   initial begin
      int w0, e0, f0, s0;

      // Reset state of both instances
      repeat (3) @(posedge clk);
      #2;
      check("rst_wrreq_a", 32'(wr_a), 32'd0);
      check("rst_busy_a",  32'(busy_a), 32'd0);
      check("rst_sof_a",   32'(sof_a), 32'd0);
      check("rst_eol_a",   32'(eol_a), 32'd0);
      check("rst_fd_a",    32'(fd_a), 32'd0);
      check("rst_data_a",  32'(data_a), 32'h000000);
      check("rst_wrreq_b", 32'(wr_b), 32'd0);
      rst_a = 1'b1;
      rst_b = 1'b1;

      // 1: single ramp frame, bounded to one frame
      w0 = wc_a; e0 = eol_cnt_a;
      push_frame(1'b0, 0, 0);
      en_a = 1'b1;
      wait_level(1'b0, 0, 400, 1'b0);
      check("s1_frame_done", 32'(fd_a), 32'd1);
      check("s1_busy_done",  32'(busy_a), 32'd0);
      check("s1_writes",     32'(wc_a - w0), 32'd64);
      check("s1_eols",       32'(eol_cnt_a - e0), 32'd4);
      check("s1_pix_5_2",    32'(cap_a), 32'h050207);
      @(posedge clk); #2;
      check("s1_fd_pulse",   32'(fd_a), 32'd0);
      repeat (4) @(posedge clk);
      #2;
      check("s1_hold_done",  32'(busy_a), 32'd0);

      // 2: colour bars after leaving DONE
      en_a = 1'b0;
      @(posedge clk); #2;
      mode_a = 2'd1;
      push_frame(1'b0, 1, 0);
      en_a = 1'b1;
      wait_level(1'b0, 0, 400, 1'b0);
      check("s2_frame_done", 32'(fd_a), 32'd1);

      // 3: ramp under periodic back-pressure
      en_a = 1'b0;
      @(posedge clk); #2;
      mode_a = 2'd0;
      push_frame(1'b0, 0, 0);
      w0 = wc_a; f0 = full_run_a; s0 = stall_a;
      en_a = 1'b1;
      wait_level(1'b0, 0, 600, 1'b1);
      check("s3_writes",      32'(wc_a - w0), 32'd64);
      check("s3_stalls_seen", 32'((full_run_a - f0) > 0), 32'd1);
      check("s3_stall_match", 32'(stall_a - s0), 32'(full_run_a - f0));
      en_a = 1'b0;

      // 4: continuous flat frames, mode switched to checker during frame 2
      mode_b = 2'd3;
      for (int f = 0; f < 3; f++) push_frame(1'b1, 3, f);
      push_frame(1'b1, 2, 3);
      en_b = 1'b1;
      wait_level(1'b1, 96, 1000, 1'b0);
      mode_b = 2'd2;
      wait_level(1'b1, 32, 1000, 1'b0);
      en_b = 1'b0;
      wait_level(1'b1, 0, 400, 1'b0);
      check("s4_fd",       32'(fd_b), 32'd1);
      check("s4_idle",     32'(busy_b), 32'd0);
      check("s4_pix_8_0",  32'(cap_b), 32'hFFFFFF);

      // 5: enable dropped mid-frame, then restart continues frame count
      rst_b = 1'b0;
      @(posedge clk); #2;
      rst_b = 1'b1;
      mode_b = 2'd0;
      push_frame(1'b1, 0, 0);
      en_b = 1'b1;
      wait_level(1'b1, 54, 400, 1'b0);
      en_b = 1'b0;
      wait_level(1'b1, 0, 400, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      check("s5_idle", 32'(busy_b), 32'd0);
      mode_b = 2'd3;
      push_frame(1'b1, 3, 1);
      en_b = 1'b1;
      wait_level(1'b1, 60, 400, 1'b0);
      en_b = 1'b0;
      wait_level(1'b1, 0, 400, 1'b0);

      // 6: reset mid-frame aborts; restart from (0,0) with frame_cnt cleared
      mode_b = 2'd0;
      push_frame(1'b1, 0, 0);
      en_b = 1'b1;
      wait_level(1'b1, 34, 400, 1'b0);
      rst_b = 1'b0;
      #1;
      check("s6_rst_wrreq", 32'(wr_b), 32'd0);
      check("s6_rst_busy",  32'(busy_b), 32'd0);
      q_b.delete();
      mode_b = 2'd3;
      @(posedge clk); #2;
      rst_b = 1'b1;
      push_frame(1'b1, 3, 0);
      wait_level(1'b1, 60, 400, 1'b0);
      en_b = 1'b0;
      wait_level(1'b1, 0, 400, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      check("s6_end_idle", 32'(busy_b), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vip_pattern_gen.md
Name: vip_pattern_gen

Overview:
Synthesizable, parametrised successor to the file-based image source that feeds the vip_core input FIFO. It generates complete frames of packed RGB pixels in one of four selectable test patterns and writes them through the standard FIFO write interface (data/wrreq/full), honouring back-pressure. It supports a bounded or continuous frame count and provides frame-boundary flags, so vip_top can be exercised on hardware and in simulation without image files.

Parameters:
DWIDTH, 24, pixel width; three equal channels of CW = DWIDTH/3 bits, packed {R,G,B} with R in the MSBs; DWIDTH must be divisible by 3.
IMG_W, 640, pixels per line; must be a multiple of 8.
IMG_H, 480, lines per frame.
XW, 12, x counter width; 2^XW > IMG_W.
YW, 12, y counter width; 2^YW > IMG_H.
FRAMES, 0, frames to emit before stopping; 0 means continuous.
SQ, 3, log2 of the checker square size in pixels.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  start / continue generation; sampled at frame boundaries.
mode  in  2  pattern select: 0 ramp, 1 colour bars, 2 checker, 3 flat frame-count.
fifo_full  in  1  downstream FIFO full.
fifo_data  out  DWIDTH  pixel data.
fifo_wrreq  out  1  write strobe; a pixel is transferred on each rising edge with fifo_wrreq=1.
sof  out  1  high with fifo_wrreq for pixel (0,0).
eol  out  1  high with fifo_wrreq for pixel x=IMG_W-1.
frame_done  out  1  one-cycle registered pulse on the cycle after the last pixel of a frame is written.
busy  out  1  high when the state is RUN.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; x, y, frame_cnt, bar_idx and bar_cnt = 0; mode_q = 0; frame_done = 0. Combinational outputs follow from these values: fifo_wrreq = 0, busy = 0, sof = eol = 0, fifo_data = pattern at (0,0) for mode_q.
- States:
  - IDLE: if enable=1, go to RUN, latch mode into mode_q, clear x, y, bar_idx and bar_cnt.
  - RUN: generate pixels as below.
  - DONE: hold until enable=0, then go to IDLE with frame_cnt cleared.
- fifo_wrreq = (state==RUN) && !fifo_full, combinational. There is no write while full. Zero-latency response to fifo_full.
- Counters advance only on a write cycle:
  - x increments.
  - At x=IMG_W-1: x wraps to 0 and y increments.
  - At the last pixel (x=IMG_W-1, y=IMG_H-1): x and y go to 0, frame_cnt increments (wraps at its width of 16 bits), frame_done pulses next cycle.
- Next state at end of frame:
  - If FRAMES!=0 and the new frame_cnt equals FRAMES: DONE.
  - Else if enable=0: IDLE.
  - Else: stay in RUN and re-latch mode into mode_q.
- Deasserting enable mid-frame has no effect until the frame completes; frames are never truncated.
- Mode changes take effect only at frame boundaries.
- Patterns, on the current (x, y) with c = CW bits and ONES = all-ones CW:
  - 0 ramp: R = x[c-1:0], G = y[c-1:0], B = (x+y)[c-1:0], wrapping modulo 2^CW.
  - 1 colour bars: BAR_W = IMG_W/8. bar_idx is 0..7; bar_cnt increments on each write and, on reaching BAR_W-1, returns to 0 and bar_idx increments; both reset at end of line. No divider. Bar colours in order: white(1,1,1), yellow(1,1,0), cyan(0,1,1), green(0,1,0), magenta(1,0,1), red(1,0,0), blue(0,0,1), black(0,0,0), where 1 = ONES and 0 = zero.
  - 2 checker: all channels = ONES if (x>>SQ)[0] ^ (y>>SQ)[0], else 0.
  - 3 flat: all channels = frame_cnt[c-1:0].
- sof and eol are qualified by fifo_wrreq; they are 0 when fifo_wrreq=0.
- Reset asserted mid-frame aborts immediately. No partial-frame recovery; the next frame starts from (0,0).
- Pixel count per frame is exactly IMG_W*IMG_H regardless of stall pattern.

Decomposition:
- Shared package vip_pkg: mode encodings (MODE_RAMP=0, MODE_BARS=1, MODE_CHECK=2, MODE_FLAT=3), the 8-entry colour-bar RGB bit table, and state encodings (IDLE, RUN, DONE).
- One natural sub-module: vip_pattern_lut, a combinational mapping of (mode_q, x, y, bar_idx, frame_cnt) to fifo_data.
- The counters and FSM remain in vip_pattern_gen.

Test Plan:
1. DWIDTH=24, IMG_W=16, IMG_H=4, FRAMES=1, mode=0, fifo_full=0, enable=1 -> exactly 64 writes; pixel (5,2) = 0x050207; sof on the 1st write, eol on writes 16/32/48/64; frame_done 1 cycle after the 64th; state DONE, busy=0.
2. Same configuration with mode=1 -> writes 1-2 = 0xFFFFFF, writes 3-4 = 0xFFFF00, writes 15-16 = 0x000000; pattern repeats on each line.
3. mode=0, fifo_full toggled 1 of every 3 cycles -> fifo_wrreq never high while full; the 64-pixel sequence is identical to scenario 1; total stall cycles equal the full cycles within RUN.
4. FRAMES=0, mode=3, enable held 1, then mode switched to 2 during frame 2 -> frames 0/1/2 flat 0x000000/0x010101/0x020202; the checker pattern starts at frame 3, with pixel (8,0) = 0xFFFFFF for SQ=3.
5. enable dropped at pixel 10 of frame 0, FRAMES=0 -> all 64 pixels are still written, then IDLE, then no writes; re-asserting enable restarts at (0,0) with frame_cnt=1.
6. reset pulsed low at pixel 30 -> fifo_wrreq=0 asynchronously; after release with enable=1, the first write is (0,0) with sof=1 and frame_cnt=0.
